// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and
// register-address constants.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Combinational load-use detector: flags when the ID instruction reads a
// register that the load currently in EX has not yet written back.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hit
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

    // A load into x0 produces nothing to wait for.
    assign hit = ex_mem_read && (ex_rd != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage Select/flush generation, memory-wait
// FSM with timeout watchdog. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_en,
    output logic                  ifid_sel,
    output logic                  idex_sel,
    output logic                  exmem_sel,
    output logic                  memwb_sel,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  mem_err,
    output logic [1:0]            state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             mem_err_q, mem_err_n;
    logic             load_use;
    logic             run_en;

    load_use_detect u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hit         (load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            mem_err_q <= mem_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        mem_err_n  = mem_err_q;
        run_en     = 1'b0;
        pc_en      = 1'b0;
        ifid_sel   = 1'b0;
        idex_sel   = 1'b0;
        exmem_sel  = 1'b0;
        memwb_sel  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    state_n    = ST_MEM_WAIT;
                    wait_cnt_n = CNT_W'(1);
                end else begin
                    run_en = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    state_n    = ST_RUN;
                    wait_cnt_n = '0;
                    run_en     = 1'b1;
                end else if (wait_cnt == TIMEOUT_C) begin
                    state_n   = ST_ERR;
                    mem_err_n = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                end
            end
            ST_ERR: begin
                state_n = ST_ERR;
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase

        // Released cycles: branch squashes ID, so it outranks the load-use bubble.
        if (run_en) begin
            if (ex_branch_taken) begin
                pc_en      = 1'b1;
                ifid_sel   = 1'b1;
                idex_sel   = 1'b1;
                exmem_sel  = 1'b1;
                memwb_sel  = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                idex_sel   = 1'b1;
                idex_flush = 1'b1;
                exmem_sel  = 1'b1;
                memwb_sel  = 1'b1;
            end else begin
                pc_en      = 1'b1;
                ifid_sel   = 1'b1;
                idex_sel   = 1'b1;
                exmem_sel  = 1'b1;
                memwb_sel  = 1'b1;
            end
        end

        if (!rst) begin
            pc_en      = 1'b0;
            ifid_sel   = 1'b0;
            idex_sel   = 1'b0;
            exmem_sel  = 1'b0;
            memwb_sel  = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    assign mem_err = mem_err_q && rst;
    assign state_o = rst ? state : ST_RUN;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (ifid_flush) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus
// randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic       mem_req, mem_ack;
    logic       pc_en, ifid_sel, idex_sel, exmem_sel, memwb_sel;
    logic       ifid_flush, idex_flush, mem_err;
    logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: whether a memory access is outstanding, how many
    // wait cycles have been spent, and whether the watchdog has fired.
    bit          m_waiting   = 1'b0;
    bit          m_failed    = 1'b0;
    int          m_waited    = 0;
    bit          m_was_reset = 1'b0;
    logic [31:0] m_stall     = '0;
    logic [31:0] m_flush     = '0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_en           (pc_en),
        .ifid_sel        (ifid_sel),
        .idex_sel        (idex_sel),
        .exmem_sel       (exmem_sel),
        .memwb_sel       (memwb_sel),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .mem_err         (mem_err),
        .state_o         (state_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
`endif
    );

    task automatic set_idle();
        rst             = 1'b1;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        ex_rd           = 5'd0;
        id_uses_rs1     = 1'b0;
        id_uses_rs2     = 1'b0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ack         = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_read = 1'b1;
        ex_rd       = rd;
        id_rs2      = 5'd5;
        id_uses_rs2 = 1'b1;
    endtask

    // Checks the current cycle against the model, then advances one clock.
    task automatic tick(input string tag);
        logic       hit, frozen;
        logic [7:0] exp_out, got_out;
        logic [1:0] exp_state;
        #1;
        hit = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        frozen = m_failed || (m_waiting && !mem_ack) || (!m_waiting && mem_req && !mem_ack);
        // Bit order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, mem_err
        if (!rst)                 exp_out = 8'b0000_0000;
        else if (m_failed)        exp_out = 8'b0000_0001;
        else if (frozen)          exp_out = 8'b0000_0000;
        else if (ex_branch_taken) exp_out = 8'b1111_1110;
        else if (hit)             exp_out = 8'b0011_1010;
        else                      exp_out = 8'b1111_1000;
        if (!rst)           exp_state = 2'b00;
        else if (m_failed)  exp_state = 2'b10;
        else if (m_waiting) exp_state = 2'b01;
        else                exp_state = 2'b00;

        got_out = {pc_en, ifid_sel, idex_sel, exmem_sel, memwb_sel,
                   ifid_flush, idex_flush, mem_err};
        vectors++;
        assert (got_out === exp_out) else begin
            miscompares++;
            $error("FAIL %s outputs got=%b exp=%b", tag, got_out, exp_out);
        end
        vectors++;
        assert (state_o === exp_state) else begin
            miscompares++;
            $error("FAIL %s state_o got=%b exp=%b", tag, state_o, exp_state);
        end
`ifdef PIPE_CTRL_PERF_EN
        if (m_was_reset) begin
            vectors++;
            assert (stall_cycles === m_stall) else begin
                miscompares++;
                $error("FAIL %s stall_cycles got=%0d exp=%0d", tag, stall_cycles, m_stall);
            end
            vectors++;
            assert (flush_events === m_flush) else begin
                miscompares++;
                $error("FAIL %s flush_events got=%0d exp=%0d", tag, flush_events, m_flush);
            end
        end
`endif

        if (!rst) begin
            m_waiting   = 1'b0;
            m_failed    = 1'b0;
            m_waited    = 0;
            m_stall     = '0;
            m_flush     = '0;
            m_was_reset = 1'b1;
        end else begin
            if (!exp_out[7]) m_stall = m_stall + 32'd1;
            if (exp_out[2])  m_flush = m_flush + 32'd1;
            if (m_failed) begin
                m_failed = 1'b1;
            end else if (m_waiting) begin
                if (mem_ack) begin
                    m_waiting = 1'b0;
                end else if (m_waited >= MEM_TIMEOUT) begin
                    m_waiting = 1'b0;
                    m_failed  = 1'b1;
                end else begin
                    m_waited++;
                end
            end else if (mem_req && !mem_ack) begin
                m_waiting = 1'b1;
                m_waited  = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        // Reset held with a pending memory request.
        rst     = 1'b0;
        mem_req = 1'b1;
        repeat (3) tick("reset_hold");
        set_idle();
        repeat (2) tick("post_reset_idle");

        // Load-use on rs2 for two cycles, then an x0 load that must not stall.
        set_load_use(5'd5);
        repeat (2) tick("load_use");
        set_load_use(5'd0);
        tick("load_use_x0");
        set_idle();

        // Branch together with a load-use hit: branch wins.
        set_load_use(5'd5);
        ex_branch_taken = 1'b1;
        tick("branch_over_load_use");
        set_idle();
        tick("idle_after_branch");

        // Memory wait: request, four waiting cycles, release on ack.
        mem_req = 1'b1;
        tick("mem_req");
        repeat (4) tick("mem_wait");
        mem_ack = 1'b1;
        set_load_use(5'd5);
        tick("mem_release_load_use");
        set_idle();
        tick("after_release");

        // Memory waits of varying length, ack on the last cycle.
        for (int k = 1; k <= 6; k++) begin
            mem_req = 1'b1;
            mem_ack = 1'b0;
            repeat (k) tick("var_wait");
            mem_ack = 1'b1;
            ex_branch_taken = ($urandom_range(0, 1) == 1);
            tick("var_release");
            set_idle();
        end

        // Randomized traffic, occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 49) != 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ack         = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_mem_read     = ($urandom_range(0, 1) == 1);
            ex_rd           = 5'($urandom_range(0, 3));
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = ($urandom_range(0, 1) == 1);
            id_uses_rs2     = ($urandom_range(0, 1) == 1);
            tick("random");
        end

        // Watchdog: reset, then a request that is never acknowledged.
        set_idle();
        rst = 1'b0;
        tick("pre_timeout_reset");
        set_idle();
        tick("pre_timeout_idle");
        mem_req = 1'b1;
        repeat (MEM_TIMEOUT + 5) tick("timeout_wait");
        mem_ack = 1'b1;
        repeat (3) tick("late_ack_ignored");
        set_idle();
        tick("err_sticky");
        rst = 1'b0;
        tick("err_reset");
        set_idle();
        repeat (2) tick("after_err_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control-side counterpart of the pipeline registers: generates the per-stage load enables (`Select`) and bubble/flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC enable.
- Resolves three hazards:
  - load-use stalls;
  - taken-branch flushes;
  - multi-cycle data-memory waits, handled by a req/ack handshake with a timeout watchdog.
- Sits beside the datapath in the FemtoRV32 pipelined core.

Parameters:
- MEM_TIMEOUT, 15: max cycles spent in MEM_WAIT before declaring a memory error (1..2^CNT_W-1).
- CNT_W, 4: width of the wait counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- id_rs1  input  5  rs1 of instruction in ID.
- id_rs2  input  5  rs2 of instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rd  input  5  destination register of EX instruction.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- mem_req  input  1  MEM-stage instruction accesses data memory.
- mem_ack  input  1  data memory completes access this cycle.
- pc_en  output  1  PC load enable.
- ifid_sel  output  1  IF/ID Select.
- idex_sel  output  1  ID/EX Select.
- exmem_sel  output  1  EX/MEM Select.
- memwb_sel  output  1  MEM/WB Select.
- ifid_flush  output  1  load NOP into IF/ID.
- idex_flush  output  1  load bubble into ID/EX.
- mem_err  output  1  sticky memory-timeout error.
- state_o  output  2  current FSM state.

Behaviour:
- Outputs are combinational from state and current inputs, so Select takes effect at the same clock edge. State, counter and mem_err are registered.
- FSM states:
  - RUN = 2'b00
  - MEM_WAIT = 2'b01
  - ERR = 2'b10
- Reset: rst==0 at posedge → state RUN, wait_cnt 0, mem_err 0. While rst==0, all outputs are forced to 0 (pc_en, all sel, all flush); state_o reads 2'b00.
- RUN priority, highest first:
  1. Memory wait: mem_req && !mem_ack → freeze. pc_en and all sel are 0, flushes are 0. Next state MEM_WAIT; wait_cnt ← 1.
  2. Taken branch: ex_branch_taken → pc_en and all sel are 1; ifid_flush=1 and idex_flush=1.
  3. Load-use: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
     - pc_en=0, ifid_sel=0.
     - idex_sel=1 with idex_flush=1.
     - exmem_sel=1, memwb_sel=1.
  4. Otherwise: pc_en and all sel are 1; flushes are 0.
- Simultaneous events:
  - A memory wait overrides everything.
  - A branch overrides load-use, because the ID instruction is squashed.
  - The ex_rd==0 (x0) load never stalls.
- MEM_WAIT:
  - mem_ack==0: all outputs 0; wait_cnt increments. If wait_cnt==MEM_TIMEOUT, go to ERR and set mem_err=1.
  - mem_ack==1: evaluate RUN priorities 2-4 in this same cycle and go to RUN; wait_cnt ← 0.
  - Latency: an ack arriving N cycles after the req releases the pipeline at edge N.
  - Branch and load-use inputs are held stable by the frozen ID/EX register, so they are evaluated on release.
- ERR:
  - All outputs 0 except mem_err=1.
  - Stays in ERR until reset; mem_ack is ignored.
- wait_cnt never wraps: it saturates at MEM_TIMEOUT.
- Reset mid-MEM_WAIT returns to RUN with the counter cleared.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0], both cleared by reset.
  - stall_cycles increments on every cycle where pc_en==0 and rst==1, including MEM_WAIT and ERR.
  - flush_events increments on every cycle where ifid_flush==1.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encodings ST_RUN, ST_MEM_WAIT, ST_ERR;
  - REG_ADDR_W=5;
  - the x0 constant.
- Sub-module load_use_detect (purely combinational): computes the load-use hit from the ID and EX fields. It is instantiated once.
- The FSM, counter and output muxing stay in pipe_hazard_ctrl.

Test Plan:
- Reset: hold rst=0 for 3 cycles with mem_req=1 → all outputs 0, state_o=00. After release with no hazards → all sel=1, pc_en=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → pc_en=0, ifid_sel=0, idex_flush=1, exmem_sel=1 for one cycle. The same stimulus with ex_rd=0 gives no stall.
- Branch vs load-use: ex_branch_taken=1 together with a load-use hit → pc_en=1, ifid_flush=1, idex_flush=1, no stall.
- Memory wait: mem_req=1 with mem_ack asserted 4 cycles later → 4 frozen cycles in state 01, then release on the ack cycle and state 00.
- Timeout: mem_req=1, mem_ack never asserted, MEM_TIMEOUT=15 → ERR after 15 frozen cycles, mem_err=1 sticky. A late mem_ack has no effect; only rst=0 clears it.
- Perf (PIPE_CTRL_PERF_EN): a 2-cycle load-use stall sequence plus 1 branch → stall_cycles=2, flush_events=1.
